// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clock divider.
//   DIV_MIN   - smallest ratio the divider will run at.
//   hi_count  - number of high cycles in a period of n, ceil(n/2).
//   clamp_div - maps a requested ratio below DIV_MIN up to DIV_MIN.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned hi_count(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < DIV_MIN) ? DIV_MIN : n;
  endfunction

endpackage

// File: rtl/rst_stretch.sv
// rst_stretch: reset stretch chain.
//   clk_i  - source clock
//   rst_i  - synchronous active-low reset, clears the chain
//   done_o - high once STAGES cycles have elapsed since reset release
module rst_stretch
  import clk_div_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic done_o
);

  logic [STAGES-1:0] r_chain;

  // Shift form works for STAGES == 1 as well as longer chains.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_chain <= '0;
    end else begin
      r_chain <= (r_chain << 1) | STAGES'(1);
    end
  end

  assign done_o = r_chain[STAGES-1];

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable clock divider with an aligned reset.
//   clk_i  - source clock, all logic on its posedge
//   rst_i  - synchronous active-low reset
//   en_i   - divider enable; counter and clk_o hold while low
//   div_i  - requested ratio N (0 and 1 behave as 2)
//   clk_o  - registered divided clock, high ceil(N/2), low floor(N/2)
//   rst_o  - active-low reset, released on a clk_o rising edge after the stretch
//   tick_o - (CLK_DIV_TICK_EN only) one-cycle pulse with each clk_o rise
// Optional feature macro: CLK_DIV_TICK_EN.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RST_STAGES = 3,
  parameter int unsigned DIV_RST    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_o,
  output logic             rst_o
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick_o
`endif
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_n_act;
  logic             r_clk;
  logic             r_rst;

  logic [DIV_W-1:0] w_cnt_next;
  logic [DIV_W-1:0] w_n_req;
  logic [DIV_W-1:0] w_n_rst;
  logic             w_clk_next;
  logic             w_wrap;
  logic             w_done;

  rst_stretch #(
    .STAGES (RST_STAGES)
  ) u_rst_stretch (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .done_o (w_done)
  );

  always_comb begin
    w_cnt_next = (r_cnt == r_n_act - 1'b1) ? '0 : r_cnt + 1'b1;
    w_clk_next = 32'(w_cnt_next) < hi_count(32'(r_n_act));
    w_wrap     = en_i && (w_cnt_next == '0);
    w_n_req    = DIV_W'(clamp_div(32'(div_i)));
    // An undriven ratio input at reset falls back to the build-time default.
    w_n_rst    = (^div_i === 1'bx) ? DIV_W'(clamp_div(DIV_RST)) : w_n_req;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_clk   <= 1'b1;
      r_rst   <= 1'b0;
      r_n_act <= w_n_rst;
    end else begin
      if (en_i) begin
        r_cnt <= w_cnt_next;
        r_clk <= w_clk_next;
        // New ratio only takes effect at a period boundary.
        if (w_wrap) begin
          r_n_act <= w_n_req;
        end
      end
      // Release only on a wrap so rst_o rises together with clk_o.
      r_rst <= r_rst | (w_done & w_wrap);
    end
  end

  assign clk_o = r_clk;
  assign rst_o = r_rst;

`ifdef CLK_DIV_TICK_EN
  logic r_tick;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
    end
  end

  assign tick_o = r_tick;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i  = 1'b1;
  logic [7:0] div_i = 8'd2;
  logic       clk_o;
  logic       rst_o;
`ifdef CLK_DIV_TICK_EN
  logic       tick_o;
`endif

  clk_div_gen #(
    .DIV_W      (8),
    .RST_STAGES (3),
    .DIV_RST    (2)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .div_i  (div_i),
    .clk_o  (clk_o),
    .rst_o  (rst_o)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick_o (tick_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic  clk;
    logic  rst;
    logic  tick;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_exp_clk = 1'b1;

  // Drive inputs for the next posedge and queue the expected outputs after it.
  // Tick is expected on a low-to-high step of expected clk_o, never on reset.
  task automatic step(input logic rst, input logic en, input logic [7:0] div,
                      input logic eclk, input logic erst, input string name);
    exp_t e;
    @(negedge clk_i);
    rst_i  = rst;
    en_i   = en;
    div_i  = div;
    e.clk  = eclk;
    e.rst  = erst;
    e.tick = rst && eclk && !prev_exp_clk;
    e.name = name;
    prev_exp_clk = eclk;
    exp_q.push_back(e);
  endtask

  // Monitor: one output sample per source-clock edge, compared against the queue.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (clk_o !== e.clk) begin
        n_errors++;
        $display("FAIL %s clk_o: got %b want %b", e.name, clk_o, e.clk);
      end
      n_checks++;
      if (rst_o !== e.rst) begin
        n_errors++;
        $display("FAIL %s rst_o: got %b want %b", e.name, rst_o, e.rst);
      end
`ifdef CLK_DIV_TICK_EN
      n_checks++;
      if (tick_o !== e.tick) begin
        n_errors++;
        $display("FAIL %s tick_o: got %b want %b", e.name, tick_o, e.tick);
      end
`endif
    end
  end

  initial begin
    logic [7:0] small_divs [3];
    small_divs[0] = 8'd2;
    small_divs[1] = 8'd0;
    small_divs[2] = 8'd1;

    // div 2, 0, 1 all behave as N=2: clk_o 0,1,0,1, rst_o rises at edge3.
    foreach (small_divs[k]) begin
      step(1'b0, 1'b1, small_divs[k], 1'b1, 1'b0, "n2_reset");
      step(1'b1, 1'b1, small_divs[k], 1'b0, 1'b0, "n2_e0");
      step(1'b1, 1'b1, small_divs[k], 1'b1, 1'b0, "n2_e1");
      step(1'b1, 1'b1, small_divs[k], 1'b0, 1'b0, "n2_e2");
      step(1'b1, 1'b1, small_divs[k], 1'b1, 1'b1, "n2_e3");
      step(1'b1, 1'b1, small_divs[k], 1'b0, 1'b1, "n2_e4");
    end

    // N=3: 1,1,0 pattern; first wrap at edge2, release at wrap edge5.
    step(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, "n3_reset");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, "n3_e0");
    step(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, "n3_e1");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, "n3_e2");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, "n3_e3");
    step(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, "n3_e4");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, "n3_e5");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, "n3_e6");
    step(1'b1, 1'b1, 8'd3, 1'b0, 1'b1, "n3_e7");
    step(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, "n3_e8");

    // 4 -> 6 at cnt=1: current period finishes at 4, next is 3 high, 3 low.
    step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, "sw_reset");
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, "sw_e0");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, "sw_e1");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, "sw_e2");
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b1, "sw_e3");
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b1, "sw_e4");
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b1, "sw_e5");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b1, "sw_e6");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b1, "sw_e7");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b1, "sw_e8");
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b1, "sw_e9");

    // N=4, enable low 5 cycles at cnt=2: freeze, no release while frozen.
    step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, "en_reset");
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, "en_e0");
    step(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, "en_e1");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'd4, 1'b0, 1'b0, "en_frozen");
    end
    step(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, "en_resume");
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, "en_wrap");
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, "en_after");

    // N=5, one-cycle reset pulse mid-run, release on first wrap after stretch.
    step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, "rp_reset");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, "rp_e0");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, "rp_e1");
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, "rp_e2");
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, "rp_e3");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, "rp_e4");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, "rp_e5");
    step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, "rp_pulse");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, "rp_p1");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, "rp_p2");
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, "rp_p3");
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, "rp_p4");
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, "rp_p5");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk_i);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
